mem_port_arbiter: RTL and testbench

- Two-requester arbiter for the data port (port 2) of the byte-addressable, 1-cycle-latency OTTER memory.
- Requester R0 is the CPU load/store path. R1 is a secondary master (DMA/debug loader).
- Grants one transfer per cycle, supports back-to-back issue and returns read data one cycle after grant.
- Provides a lock for atomic multi-transfer sequences and a starvation guard for R1.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for data port 2 of the OTTER memory.
// R0 is the CPU load/store path, R1 is a secondary master (DMA or debug loader).
// A grant is decided combinationally in the same cycle as the request, so there is
// no grant latency and transfers can issue back to back.
// Read data returns one cycle after the grant and is routed back to whichever
// requester issued the read.
// A requester can hold LOCK to keep ownership of the port across a multi-transfer
// atomic sequence.
// In fixed-priority mode, a saturating wait counter force-grants R1 after it has
// been denied MAX_WAIT times in a row.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int RR       = 0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        R0_REQ,
  input  logic        R0_LOCK,
  input  logic        R0_WE,
  input  logic [31:0] R0_ADDR,
  input  logic [31:0] R0_WDATA,
  input  logic [1:0]  R0_SIZE,
  input  logic        R0_SIGN,
  output logic        R0_ACK,
  output logic        R0_RVALID,
  output logic [31:0] R0_RDATA,
  input  logic        R1_REQ,
  input  logic        R1_LOCK,
  input  logic        R1_WE,
  input  logic [31:0] R1_ADDR,
  input  logic [31:0] R1_WDATA,
  input  logic [1:0]  R1_SIZE,
  input  logic        R1_SIGN,
  output logic        R1_ACK,
  output logic        R1_RVALID,
  output logic [31:0] R1_RDATA,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_READ2,
  output logic        MEM_WRITE2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          rd_owner_valid_q, rd_owner_valid_d;
  logic          rd_owner_q, rd_owner_d;

  logic idle_win_valid;
  logic idle_win;
  logic grant_valid;
  logic grant_idx;
  logic bus_sel;
  logic sel_we;
  logic sel_lock;

  // Unlocked arbitration: a lone requester wins. On a tie, round-robin mode picks the
  // requester that did not win last. Fixed mode picks R0 unless R1 has been denied
  // MAX_WAIT times.
  always_comb begin
    idle_win_valid = R0_REQ | R1_REQ;
    idle_win       = R1_REQ;
    if (R0_REQ && R1_REQ) begin
      if (RR != 0) begin
        idle_win = ~last_grant_q;
      end else begin
        idle_win = (wait_cnt_q == WAIT_MAX);
      end
    end
  end

  // While a lock is held only its owner may win. Once the owner drops LOCK, normal
  // arbitration takes over in that same cycle.
  always_comb begin
    grant_valid = idle_win_valid;
    grant_idx   = idle_win;
    case (state_q)
      LOCK0: begin
        if (R0_LOCK) begin
          grant_valid = R0_REQ;
          grant_idx   = 1'b0;
        end
      end
      LOCK1: begin
        if (R1_LOCK) begin
          grant_valid = R1_REQ;
          grant_idx   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Steer the winner's transfer onto the memory port. With no winner, the buses carry
  // R0's fields and both strobes stay low.
  always_comb begin
    bus_sel    = grant_valid & grant_idx;
    sel_we     = bus_sel ? R1_WE   : R0_WE;
    sel_lock   = bus_sel ? R1_LOCK : R0_LOCK;
    MEM_ADDR2  = bus_sel ? R1_ADDR  : R0_ADDR;
    MEM_DIN2   = bus_sel ? R1_WDATA : R0_WDATA;
    MEM_SIZE   = bus_sel ? R1_SIZE  : R0_SIZE;
    MEM_SIGN   = bus_sel ? R1_SIGN  : R0_SIGN;
    MEM_READ2  = grant_valid & ~sel_we;
    MEM_WRITE2 = grant_valid & sel_we;
    R0_ACK     = grant_valid & ~grant_idx;
    R1_ACK     = grant_valid & grant_idx;
  end

  // Next-state terms: lock ownership, last winner, R1 starvation count, and the owner
  // of the read in flight.
  always_comb begin
    state_d          = IDLE;
    last_grant_d     = last_grant_q;
    wait_cnt_d       = '0;
    rd_owner_valid_d = MEM_READ2;
    rd_owner_d       = grant_idx;

    if (grant_valid) begin
      last_grant_d = grant_idx;
      if (sel_lock) begin
        state_d = grant_idx ? LOCK1 : LOCK0;
      end
    end else begin
      case (state_q)
        LOCK0:   state_d = R0_LOCK ? LOCK0 : IDLE;
        LOCK1:   state_d = R1_LOCK ? LOCK1 : IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (R1_REQ && !R1_ACK) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
    end
  end

  // All arbiter state. Reset drops any lock and any pending read response, and biases
  // the first round-robin tie toward R0.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      wait_cnt_q       <= '0;
      rd_owner_valid_q <= 1'b0;
      rd_owner_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      wait_cnt_q       <= wait_cnt_d;
      rd_owner_valid_q <= rd_owner_valid_d;
      rd_owner_q       <= rd_owner_d;
    end
  end

  assign R0_RVALID = rd_owner_valid_q & ~rd_owner_q;
  assign R1_RVALID = rd_owner_valid_q & rd_owner_q;
  assign R0_RDATA  = R0_RVALID ? MEM_DOUT2 : 32'h0;
  assign R1_RDATA  = R1_RVALID ? MEM_DOUT2 : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter.
// Drives one fixed-priority instance (g=0) and one round-robin instance (g=1) from
// the same requester inputs.
// A transaction-level model tracks each instance: who owns the port, who won last,
// the denial count, and the pending read.
// On top of the model there is a table of directed vectors and a few multi-cycle
// sequences.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req   [2];
  logic        lock  [2];
  logic        we    [2];
  logic        sgn   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  size  [2];
  logic [31:0] dout;

  logic        ack0_o  [2];
  logic        ack1_o  [2];
  logic        rv0_o   [2];
  logic        rv1_o   [2];
  logic [31:0] rd0_o   [2];
  logic [31:0] rd1_o   [2];
  logic [31:0] maddr_o [2];
  logic [31:0] mdin_o  [2];
  logic        mrd_o   [2];
  logic        mwr_o   [2];
  logic [1:0]  msize_o [2];
  logic        msign_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .RR(g)) u_dut (
      .CLK(clk), .RESET_N(rst_n),
      .R0_REQ(req[0]), .R0_LOCK(lock[0]), .R0_WE(we[0]), .R0_ADDR(addr[0]),
      .R0_WDATA(wdata[0]), .R0_SIZE(size[0]), .R0_SIGN(sgn[0]),
      .R0_ACK(ack0_o[g]), .R0_RVALID(rv0_o[g]), .R0_RDATA(rd0_o[g]),
      .R1_REQ(req[1]), .R1_LOCK(lock[1]), .R1_WE(we[1]), .R1_ADDR(addr[1]),
      .R1_WDATA(wdata[1]), .R1_SIZE(size[1]), .R1_SIGN(sgn[1]),
      .R1_ACK(ack1_o[g]), .R1_RVALID(rv1_o[g]), .R1_RDATA(rd1_o[g]),
      .MEM_ADDR2(maddr_o[g]), .MEM_DIN2(mdin_o[g]), .MEM_READ2(mrd_o[g]),
      .MEM_WRITE2(mwr_o[g]), .MEM_SIZE(msize_o[g]), .MEM_SIGN(msign_o[g]),
      .MEM_DOUT2(dout)
    );
  end

  int n_vec;
  int n_cmp;
  int n_fail;

  // Model state per instance. An owner or pending value of -1 means none.
  int m_owner [2];
  int m_last  [2];
  int m_wait  [2];
  int m_pend  [2];

  // ctl  = {r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock}
  // expd = {ack0, ack1, mem_read, mem_write, rvalid0, rvalid1}, taken from the round-robin instance
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] dout;
    logic [5:0]  expd;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_owner[g] = -1;
      m_last[g]  = 1;
      m_wait[g]  = 0;
      m_pend[g]  = -1;
    end
  endtask

  function automatic int model_winner(input int g);
    if (m_owner[g] >= 0 && lock[m_owner[g]]) return req[m_owner[g]] ? m_owner[g] : -1;
    if (req[0] && req[1]) begin
      if (g == 1) return 1 - m_last[g];
      return (m_wait[g] >= MAX_WAIT) ? 1 : 0;
    end
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_advance(input int g, input int w);
    if (w >= 0) begin
      m_last[g]  = w;
      m_owner[g] = lock[w] ? w : -1;
    end else if (!(m_owner[g] >= 0 && lock[m_owner[g]])) begin
      m_owner[g] = -1;
    end
    if (req[1] && w != 1) m_wait[g] = (m_wait[g] + 1 > MAX_WAIT) ? MAX_WAIT : m_wait[g] + 1;
    else m_wait[g] = 0;
    m_pend[g] = (w >= 0 && !we[w]) ? w : -1;
  endtask

  task automatic applyStimulus(input logic [5:0] ctl, input logic [31:0] d);
    {req[0], we[0], lock[0], req[1], we[1], lock[1]} = ctl;
    dout = d;
  endtask

  // Compares both instances against the model for the current inputs, then advances
  // the model across the coming edge.
  task automatic checkOutput();
    for (int g = 0; g < 2; g++) begin
      int w;
      w = model_winner(g);
      chk($sformatf("g%0d r0_ack", g), 32'(ack0_o[g]), 32'(w == 0));
      chk($sformatf("g%0d r1_ack", g), 32'(ack1_o[g]), 32'(w == 1));
      chk($sformatf("g%0d mem_read", g), 32'(mrd_o[g]), 32'(w >= 0 && !we[w < 0 ? 0 : w]));
      chk($sformatf("g%0d mem_write", g), 32'(mwr_o[g]), 32'(w >= 0 && we[w < 0 ? 0 : w]));
      if (w >= 0) begin
        chk($sformatf("g%0d mem_addr", g), maddr_o[g], addr[w]);
        chk($sformatf("g%0d mem_din", g), mdin_o[g], wdata[w]);
        chk($sformatf("g%0d mem_size", g), 32'(msize_o[g]), 32'(size[w]));
        chk($sformatf("g%0d mem_sign", g), 32'(msign_o[g]), 32'(sgn[w]));
      end
      chk($sformatf("g%0d r0_rvalid", g), 32'(rv0_o[g]), 32'(m_pend[g] == 0));
      chk($sformatf("g%0d r1_rvalid", g), 32'(rv1_o[g]), 32'(m_pend[g] == 1));
      chk($sformatf("g%0d r0_rdata", g), rd0_o[g], (m_pend[g] == 0) ? dout : 32'h0);
      chk($sformatf("g%0d r1_rdata", g), rd1_o[g], (m_pend[g] == 1) ? dout : 32'h0);
      model_advance(g, w);
    end
    n_vec++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [5:0] ctl, input logic [31:0] d);
    applyStimulus(ctl, d);
    #3;
    checkOutput();
    tick();
  endtask

  initial begin
    n_vec  = 0;
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = (i == 0) ? 32'h0000_0100 : 32'h0000_0200;
      wdata[i] = (i == 0) ? 32'h0BAD_F00D : 32'hCAFE_0001;
      size[i]  = 2'b10;
      sgn[i]   = 1'b0;
    end
    applyStimulus(6'b000000, 32'h0);
    model_reset();

    tbl[0]  = '{6'b100000, 32'h0000_0000, 6'b101000, 32'h0,         32'h0};
    tbl[1]  = '{6'b000000, 32'hDEAD_BEEF, 6'b000010, 32'hDEAD_BEEF, 32'h0};
    tbl[2]  = '{6'b100100, 32'h1111_1111, 6'b011000, 32'h0,         32'h0};
    tbl[3]  = '{6'b100100, 32'h2222_2222, 6'b101001, 32'h0,         32'h2222_2222};
    tbl[4]  = '{6'b100100, 32'h3333_3333, 6'b011010, 32'h3333_3333, 32'h0};
    tbl[5]  = '{6'b000111, 32'h4444_4444, 6'b010101, 32'h0,         32'h4444_4444};
    tbl[6]  = '{6'b100101, 32'h5555_5555, 6'b011000, 32'h0,         32'h0};
    tbl[7]  = '{6'b100000, 32'h6666_6666, 6'b101001, 32'h0,         32'h6666_6666};
    tbl[8]  = '{6'b110000, 32'h7777_7777, 6'b100110, 32'h7777_7777, 32'h0};
    tbl[9]  = '{6'b101000, 32'h8888_8888, 6'b101000, 32'h0,         32'h0};
    tbl[10] = '{6'b001100, 32'h9999_9999, 6'b000010, 32'h9999_9999, 32'h0};
    tbl[11] = '{6'b000100, 32'hAAAA_AAAA, 6'b011000, 32'h0,         32'h0};
    tbl[12] = '{6'b000000, 32'hBBBB_BBBB, 6'b000001, 32'h0,         32'hBBBB_BBBB};
    tbl[13] = '{6'b000000, 32'hCCCC_CCCC, 6'b000000, 32'h0,         32'h0};

    // Reset state
    tick();
    #2;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst g%0d rvalid0", g), 32'(rv0_o[g]), 32'h0);
      chk($sformatf("rst g%0d rvalid1", g), 32'(rv1_o[g]), 32'h0);
      chk($sformatf("rst g%0d mem_read", g), 32'(mrd_o[g]), 32'h0);
      chk($sformatf("rst g%0d mem_write", g), 32'(mwr_o[g]), 32'h0);
      chk($sformatf("rst g%0d rdata0", g), rd0_o[g], 32'h0);
    end
    tick();
    rst_n = 1'b1;

    // Directed table, expectations taken from the round-robin instance
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].ctl, tbl[i].dout);
      #3;
      chk($sformatf("row%0d ack0", i), 32'(ack0_o[1]), 32'(tbl[i].expd[5]));
      chk($sformatf("row%0d ack1", i), 32'(ack1_o[1]), 32'(tbl[i].expd[4]));
      chk($sformatf("row%0d mem_read", i), 32'(mrd_o[1]), 32'(tbl[i].expd[3]));
      chk($sformatf("row%0d mem_write", i), 32'(mwr_o[1]), 32'(tbl[i].expd[2]));
      chk($sformatf("row%0d rvalid0", i), 32'(rv0_o[1]), 32'(tbl[i].expd[1]));
      chk($sformatf("row%0d rvalid1", i), 32'(rv1_o[1]), 32'(tbl[i].expd[0]));
      chk($sformatf("row%0d rdata0", i), rd0_o[1], tbl[i].rdata0);
      chk($sformatf("row%0d rdata1", i), rd1_o[1], tbl[i].rdata1);
      if (tbl[i].expd[5]) chk($sformatf("row%0d addr0", i), maddr_o[1], 32'h0000_0100);
      if (tbl[i].expd[4]) chk($sformatf("row%0d addr1", i), maddr_o[1], 32'h0000_0200);
      checkOutput();
      tick();
    end

    // Starvation escape: fixed mode grants R1 on every 9th cycle
    cycle(6'b000000, 32'h0);
    for (int i = 0; i < 27; i++) begin
      applyStimulus(6'b100100, $urandom);
      #3;
      chk($sformatf("starve i%0d r1_ack", i), 32'(ack1_o[0]), 32'((i % 9) == 8));
      checkOutput();
      tick();
    end

    // R1 holds lock for 12 cycles in fixed mode; R0 stays stalled
    cycle(6'b000000, 32'h0);
    applyStimulus(6'b000101, 32'h0);
    #3;
    chk("lock first r1_ack", 32'(ack1_o[0]), 32'h1);
    checkOutput();
    tick();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(6'b100101, $urandom);
      #3;
      chk($sformatf("lock i%0d r0_ack", i), 32'(ack0_o[0]), 32'h0);
      checkOutput();
      tick();
    end
    applyStimulus(6'b100000, 32'h0);
    #3;
    chk("lock release r0_ack", 32'(ack0_o[0]), 32'h1);
    checkOutput();
    tick();

    // Withdrawn R1 loses its starvation credit; R0 write has no read response
    cycle(6'b000000, 32'h0);
    for (int i = 0; i < 5; i++) cycle(6'b100100, $urandom);
    addr[0]  = 32'h0000_0300;
    wdata[0] = 32'h1234_5678;
    size[0]  = 2'b10;
    applyStimulus(6'b110000, 32'h0);
    #3;
    chk("write strobe", 32'(mwr_o[0]), 32'h1);
    chk("write din", mdin_o[0], 32'h1234_5678);
    chk("write no read", 32'(mrd_o[0]), 32'h0);
    checkOutput();
    tick();
    applyStimulus(6'b000000, 32'h0);
    #3;
    chk("write no rvalid", 32'(rv0_o[0]), 32'h0);
    checkOutput();
    tick();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(6'b100100, $urandom);
      #3;
      chk($sformatf("nocredit i%0d r1_ack", i), 32'(ack1_o[0]), 32'(i == 8));
      checkOutput();
      tick();
    end

    // Reset asserted right after a read grant suppresses the response
    cycle(6'b000000, 32'h0);
    applyStimulus(6'b100000, 32'h5A5A_5A5A);
    #3;
    chk("rst grant r0_ack", 32'(ack0_o[1]), 32'h1);
    checkOutput();
    #1;
    rst_n = 1'b0;
    applyStimulus(6'b000000, 32'h0);
    model_reset();
    tick();
    dout = 32'hFFFF_0000;
    #2;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("midrst g%0d rvalid0", g), 32'(rv0_o[g]), 32'h0);
      chk($sformatf("midrst g%0d rdata0", g), rd0_o[g], 32'h0);
    end
    rst_n = 1'b1;
    #1;
    checkOutput();
    tick();
    applyStimulus(6'b100100, 32'h0);
    #3;
    chk("post rst tie r0_ack", 32'(ack0_o[1]), 32'h1);
    checkOutput();
    tick();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < 2; r++) begin
        req[r]   = 1'($urandom_range(0, 3) != 0);
        we[r]    = 1'($urandom_range(0, 1));
        lock[r]  = 1'($urandom_range(0, 4) == 0);
        sgn[r]   = 1'($urandom_range(0, 1));
        size[r]  = 2'($urandom_range(0, 2));
        addr[r]  = $urandom;
        wdata[r] = $urandom;
      end
      dout = $urandom;
      #3;
      checkOutput();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
